dispatch_queue: RTL and testbench
=================================

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 The block SHALL have parameter QUEUE_DEPTH, default 8, meaning the number of DISPATCH_RS_PACKET entries; it SHALL be a power of two and at least 2*`MACHINE_WIDTH.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pipe_flush  input  1  discard all queued and incoming packets.
REQ-005 in_pkt  input  DISPATCH_RS_PACKET [0:`MACHINE_WIDTH-1]  renamed group from rename; the packet_valid bit marks live lanes.
REQ-006 in_ready  output  1  queue accepts the current in_pkt group this cycle.
REQ-007 dispatch_pkt  output  DISPATCH_RS_PACKET [0:`MACHINE_WIDTH-1]  oldest queued packets, lane 0 oldest, to the RS bank.
REQ-008 dispatch_pkt_ready  input  [`MACHINE_WIDTH-1:0]  per-lane accept from the RS bank.
REQ-009 q_count  output  [$clog2(QUEUE_DEPTH):0]  number of occupied entries.
REQ-010 q_empty / q_full  output  1 each  true when q_count==0 / q_count==QUEUE_DEPTH.

Function
REQ-011 Storage SHALL be a circular buffer with head and tail pointers of $clog2(QUEUE_DEPTH)+1 bits; the MSB is the wrap bit, and the pointers wrap modulo 2*QUEUE_DEPTH.
REQ-012 in_ready SHALL equal (QUEUE_DEPTH - q_count) >= `MACHINE_WIDTH, computed from registered state only and never from in_pkt or dispatch_pkt_ready.
REQ-013 Enqueue fire SHALL be in_ready & !pipe_flush; on fire, valid lanes of in_pkt are compacted in ascending lane order and written at tail, tail+1, ...; tail advances by the valid-lane count (0..`MACHINE_WIDTH).
REQ-014 Invalid lanes SHALL NOT occupy entries; a group with zero valid lanes SHALL be a no-op.
REQ-015 Enqueue is all-or-nothing; when in_ready=0 the group is not taken and rename must hold it.
REQ-016 dispatch_pkt[k] SHALL present entry head+k with packet_valid=1 when k<q_count, else all fields 0 with packet_valid=0.
REQ-017 Dequeue count SHALL equal the number of leading lanes, starting at lane 0, with both dispatch_pkt[k].packet_valid and dispatch_pkt_ready[k]; the first failing lane stops counting.
REQ-018 head SHALL advance by the dequeue count; lanes beyond the first non-accepted lane are not consumed even if ready.
REQ-019 Latency: a packet enqueued in cycle N SHALL appear on dispatch_pkt no earlier than cycle N+1; there is no enqueue-to-dispatch bypass.
REQ-020 Simultaneous enqueue and dequeue SHALL both take effect: q_count_next = q_count + enq - deq.
REQ-021 in_ready SHALL use the pre-dequeue count, so same-cycle frees are not credited.
REQ-022 pipe_flush SHALL take priority: next cycle head=tail=0 and q_count=0, with enqueue and dequeue suppressed in the flush cycle.
REQ-023 Order SHALL be preserved across pointer wrap; the entry at index QUEUE_DEPTH-1 is followed by entry 0.
REQ-024 q_count SHALL never exceed QUEUE_DEPTH or underflow; an assertion checks both.

Reset
REQ-025 On rst_n low, asynchronously: head=0, tail=0, q_count=0, q_empty=1, q_full=0, in_ready=1, all dispatch_pkt packet_valid=0.
REQ-026 Entry payload storage SHALL need no reset; outputs SHALL mask payload with the valid bits.
REQ-027 Reset asserted mid-operation SHALL discard all contents identically to REQ-025, with no partial dequeue.

Structure
REQ-028 DISPATCH_RS_PACKET, `MACHINE_WIDTH and `ROB_WIDTH SHALL come from the shared sys_defs package/header; the block SHALL define no new global typedefs.
REQ-029 The leading-ones lane counter SHALL be one sub-module, lead_ones_cnt, parameterised on `MACHINE_WIDTH.
REQ-030 Lane compaction and pointer arithmetic SHALL stay inline, with no sub-module.

Verification
REQ-031 Reset, then 4 valid lanes in one cycle -> in_ready=1; next cycle q_count=4 and dispatch_pkt lanes 0..3 valid in lane order.
REQ-032 in_pkt valid mask 4'b1010 with ready=0 -> q_count=2; dispatch lane0=in lane1 and dispatch lane1=in lane3, lanes 2..3 invalid.
REQ-033 q_count=5, dispatch_pkt_ready=4'b1101 -> only lane 0 consumed, q_count=4, and the new head is the old lane-1 packet.
REQ-034 q_count=5, QUEUE_DEPTH=8 -> in_ready=0 with the group held; after a dequeue of 3 -> in_ready=1 next cycle.
REQ-035 Run 20 cycles of 3-in/3-out traffic crossing the wrap -> order preserved, q_count stays stable, and pointer wrap bits toggle.
REQ-036 q_count=6 with pipe_flush and a valid in_pkt in the same cycle -> next cycle q_count=0, all outputs invalid, and the incoming group dropped.

Source files
------------

// File: rtl/dispatch_queue_pkg.sv
// Local constants and helpers for the dispatch queue; no new global types.
`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 4
`endif

package dispatch_queue_pkg;

    localparam int MW    = `MACHINE_WIDTH;
    localparam int CNT_W = $clog2(MW + 1);

    function automatic logic [CNT_W-1:0] count_ones(input logic [MW-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MW; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/sys_defs.sv
// Shared machine-wide definitions: superscalar width, ROB index width and the
// packet carried from rename through dispatch into the RS bank.
`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 4
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif

package sys_defs;

    typedef struct packed {
        logic                   packet_valid;
        logic [31:0]            pc;
        logic [31:0]            inst;
        logic [`ROB_WIDTH-1:0]  rob_idx;
        logic [5:0]             dest_tag;
    } DISPATCH_RS_PACKET;

endpackage

// File: rtl/lead_ones_cnt.sv
// Counts consecutive set bits starting at bit 0; the first clear bit stops the count.
`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 4
`endif

module lead_ones_cnt #(
    parameter  int W  = `MACHINE_WIDTH,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] cnt
);

    always_comb begin
        logic stop;
        stop = 1'b0;
        cnt  = '0;
        for (int i = 0; i < W; i++) begin
            if (!stop && bits[i]) cnt = cnt + CW'(1);
            else                  stop = 1'b1;
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue between rename and the RS bank: compacting group
// enqueue, in-order partial dequeue, flush, circular storage with wrap-bit pointers.
`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 4
`endif

module dispatch_queue
    import sys_defs::*;
    import dispatch_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pipe_flush,
    input  DISPATCH_RS_PACKET            in_pkt [0:`MACHINE_WIDTH-1],
    output logic                         in_ready,
    output DISPATCH_RS_PACKET            dispatch_pkt [0:`MACHINE_WIDTH-1],
    input  logic [`MACHINE_WIDTH-1:0]    dispatch_pkt_ready,
    output logic [$clog2(QUEUE_DEPTH):0] q_count,
    output logic                         q_empty,
    output logic                         q_full
);

    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]   head, tail;
    DISPATCH_RS_PACKET  mem [QUEUE_DEPTH];

    logic [MW-1:0]      in_mask;
    logic [CNT_W-1:0]   enq_cnt;
    logic [IDX_W-1:0]   wr_idx [MW];
    logic               enq_fire;
    logic [MW-1:0]      disp_vld;
    logic [CNT_W-1:0]   deq_cnt;

    // Occupancy falls straight out of the wrap-bit pointers.
    assign q_count  = tail - head;
    assign q_empty  = (q_count == '0);
    assign q_full   = (q_count == PTR_W'(QUEUE_DEPTH));
    assign in_ready = (PTR_W'(QUEUE_DEPTH) - q_count) >= PTR_W'(MW);
    assign enq_fire = in_ready & ~pipe_flush;

    always_comb begin
        for (int i = 0; i < MW; i++) in_mask[i] = in_pkt[i].packet_valid;
    end

    assign enq_cnt = count_ones(in_mask);

    // Valid lanes land in consecutive slots from tail; invalid lanes take none.
    always_comb begin
        logic [IDX_W-1:0] slot;
        slot = tail[IDX_W-1:0];
        for (int i = 0; i < MW; i++) begin
            wr_idx[i] = slot;
            if (in_mask[i]) slot = slot + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MW; i++) begin
            if (enq_fire && in_mask[i]) mem[wr_idx[i]] <= in_pkt[i];
        end
    end

    // Payload is unreset, so lanes beyond the occupancy are forced to zero.
    always_comb begin
        for (int k = 0; k < MW; k++) begin
            disp_vld[k]     = PTR_W'(k) < q_count;
            dispatch_pkt[k] = '0;
            if (disp_vld[k]) begin
                dispatch_pkt[k] = mem[IDX_W'(head[IDX_W-1:0] + IDX_W'(k))];
                dispatch_pkt[k].packet_valid = 1'b1;
            end
        end
    end

    lead_ones_cnt #(.W(MW)) u_deq_cnt (
        .bits (disp_vld & dispatch_pkt_ready),
        .cnt  (deq_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (pipe_flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + PTR_W'(deq_cnt);
            if (enq_fire) tail <= tail + PTR_W'(enq_cnt);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        q_count <= PTR_W'(QUEUE_DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        PTR_W'(deq_cnt) <= q_count);
    a_enq_fits: assert property (@(posedge clk) disable iff (!rst_n)
        enq_fire |-> (q_count + PTR_W'(enq_cnt)) <= PTR_W'(QUEUE_DEPTH));

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomised and directed bench for dispatch_queue against a packet-queue model.
`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 4
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif

module tb_dispatch_queue;
    import sys_defs::*;

    localparam int MW    = `MACHINE_WIDTH;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pipe_flush = 1'b0;
    DISPATCH_RS_PACKET  in_pkt [0:MW-1];
    DISPATCH_RS_PACKET  dispatch_pkt [0:MW-1];
    logic               in_ready;
    logic [MW-1:0]      rdy = '0;
    logic [CW-1:0]      q_count;
    logic               q_empty, q_full;

    int vectors = 0;
    int miscompares = 0;
    DISPATCH_RS_PACKET mq[$];

    always #5 clk = ~clk;

    dispatch_queue #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pipe_flush         (pipe_flush),
        .in_pkt             (in_pkt),
        .in_ready           (in_ready),
        .dispatch_pkt       (dispatch_pkt),
        .dispatch_pkt_ready (rdy),
        .q_count            (q_count),
        .q_empty            (q_empty),
        .q_full             (q_full)
    );

    function automatic DISPATCH_RS_PACKET rand_pkt(input logic v);
        DISPATCH_RS_PACKET p;
        logic [31:0] r;
        p.packet_valid = v;
        p.pc           = $urandom;
        p.inst         = $urandom;
        r              = $urandom;
        p.rob_idx      = r[`ROB_WIDTH-1:0];
        p.dest_tag     = r[31:26];
        return p;
    endfunction

    task automatic set_group(input logic [MW-1:0] mask);
        for (int i = 0; i < MW; i++) in_pkt[i] = rand_pkt(mask[i]);
    endtask

    // Model step: apply the queue rules to the current inputs, then clock.
    task automatic cycle();
        int d;
        bit can_take;
        if (!rst_n || pipe_flush) begin
            mq.delete();
        end else begin
            can_take = (DEPTH - mq.size()) >= MW;
            d = 0;
            for (int k = 0; k < MW; k++)
                if (d == k && k < mq.size() && rdy[k]) d++;
            repeat (d) void'(mq.pop_front());
            if (can_take)
                for (int i = 0; i < MW; i++)
                    if (in_pkt[i].packet_valid) mq.push_back(in_pkt[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        pipe_flush = 1'b1;
        rdy = '0;
        set_group('0);
        cycle();
        pipe_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy = '0;
        set_group('0);
        #3;
        vectors++; if (q_count !== '0) begin miscompares++; $display("FAIL reset_count got %0d want 0", q_count); end
        vectors++; if (q_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", q_empty); end
        vectors++; if (q_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", q_full); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", in_ready); end
        for (int k = 0; k < MW; k++) begin
            vectors++;
            if (dispatch_pkt[k].packet_valid !== 1'b0) begin
                miscompares++; $display("FAIL reset_lane%0d_valid got %b want 0", k, dispatch_pkt[k].packet_valid);
            end
        end
        mq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_four_lanes();
        DISPATCH_RS_PACKET g [0:MW-1];
        drain();
        set_group(4'b1111);
        g = in_pkt;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL four_ready got %b want 1", in_ready); end
        vectors++; if (dispatch_pkt[0].packet_valid !== 1'b0) begin miscompares++; $display("FAIL four_bypass got %b want 0", dispatch_pkt[0].packet_valid); end
        cycle();
        set_group('0);
        #1;
        vectors++; if (q_count !== 4) begin miscompares++; $display("FAIL four_count got %0d want 4", q_count); end
        for (int k = 0; k < MW; k++) begin
            vectors++;
            if (dispatch_pkt[k] !== g[k]) begin
                miscompares++; $display("FAIL four_lane%0d got %h want %h", k, dispatch_pkt[k], g[k]);
            end
        end
        rdy = 4'b1111;
        cycle();
        rdy = '0;
        #1;
        vectors++; if (q_empty !== 1'b1) begin miscompares++; $display("FAIL four_drain_empty got %b want 1", q_empty); end
    endtask

    task automatic test_sparse_mask();
        DISPATCH_RS_PACKET g [0:MW-1];
        drain();
        set_group(4'b1010);
        g = in_pkt;
        cycle();
        set_group('0);
        #1;
        vectors++; if (q_count !== 2) begin miscompares++; $display("FAIL sparse_count got %0d want 2", q_count); end
        vectors++; if (dispatch_pkt[0] !== g[1]) begin miscompares++; $display("FAIL sparse_lane0 got %h want %h", dispatch_pkt[0], g[1]); end
        vectors++; if (dispatch_pkt[1] !== g[3]) begin miscompares++; $display("FAIL sparse_lane1 got %h want %h", dispatch_pkt[1], g[3]); end
        vectors++; if (dispatch_pkt[2] !== '0) begin miscompares++; $display("FAIL sparse_lane2 got %h want 0", dispatch_pkt[2]); end
        vectors++; if (dispatch_pkt[3] !== '0) begin miscompares++; $display("FAIL sparse_lane3 got %h want 0", dispatch_pkt[3]); end
    endtask

    task automatic test_partial_accept();
        DISPATCH_RS_PACKET e1;
        drain();
        set_group(4'b1111); cycle();
        set_group(4'b0001); cycle();
        set_group('0);
        rdy = 4'b1101;
        e1 = mq[1];
        #1;
        vectors++; if (q_count !== 5) begin miscompares++; $display("FAIL partial_pre_count got %0d want 5", q_count); end
        cycle();
        rdy = '0;
        #1;
        vectors++; if (q_count !== 4) begin miscompares++; $display("FAIL partial_count got %0d want 4", q_count); end
        vectors++; if (dispatch_pkt[0] !== e1) begin miscompares++; $display("FAIL partial_head got %h want %h", dispatch_pkt[0], e1); end
    endtask

    task automatic test_backpressure();
        DISPATCH_RS_PACKET g [0:MW-1];
        drain();
        set_group(4'b1111); cycle();
        set_group(4'b0001); cycle();
        set_group(4'b1111);
        g = in_pkt;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
        cycle();
        vectors++; if (q_count !== 5) begin miscompares++; $display("FAIL bp_held_count got %0d want 5", q_count); end
        rdy = 4'b0111;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_no_credit got %b want 0", in_ready); end
        cycle();
        rdy = '0;
        #1;
        vectors++; if (q_count !== 2) begin miscompares++; $display("FAIL bp_after_deq got %0d want 2", q_count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_again got %b want 1", in_ready); end
        cycle();
        set_group('0);
        #1;
        vectors++; if (q_count !== 6) begin miscompares++; $display("FAIL bp_taken_count got %0d want 6", q_count); end
        vectors++; if (dispatch_pkt[2] !== g[0]) begin miscompares++; $display("FAIL bp_taken_lane2 got %h want %h", dispatch_pkt[2], g[0]); end
    endtask

    task automatic test_flush();
        drain();
        set_group(4'b1111); cycle();
        set_group(4'b0011); cycle();
        pipe_flush = 1'b1;
        set_group(4'b1111);
        rdy = 4'b1111;
        #1;
        vectors++; if (q_count !== 6) begin miscompares++; $display("FAIL flush_pre_count got %0d want 6", q_count); end
        cycle();
        pipe_flush = 1'b0;
        set_group('0);
        rdy = '0;
        #1;
        vectors++; if (q_count !== 0) begin miscompares++; $display("FAIL flush_count got %0d want 0", q_count); end
        vectors++; if (q_empty !== 1'b1) begin miscompares++; $display("FAIL flush_empty got %b want 1", q_empty); end
        for (int k = 0; k < MW; k++) begin
            vectors++;
            if (dispatch_pkt[k] !== '0) begin miscompares++; $display("FAIL flush_lane%0d got %h want 0", k, dispatch_pkt[k]); end
        end
        cycle();
        vectors++; if (q_count !== 0) begin miscompares++; $display("FAIL flush_dropped got %0d want 0", q_count); end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] exp_head;
        drain();
        set_group(4'b0111);
        cycle();
        rdy = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            set_group(4'b0111);
            exp_head = CW'((3 * i) % (2 * DEPTH));
            #1;
            vectors++; if (q_count !== 3) begin miscompares++; $display("FAIL wrap_count[%0d] got %0d want 3", i, q_count); end
            vectors++; if (dut.head !== exp_head) begin miscompares++; $display("FAIL wrap_head[%0d] got %0d want %0d", i, dut.head, exp_head); end
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (dispatch_pkt[k] !== mq[k]) begin miscompares++; $display("FAIL wrap_lane%0d[%0d] got %h want %h", k, i, dispatch_pkt[k], mq[k]); end
            end
            vectors++; if (dispatch_pkt[3].packet_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_lane3[%0d] got 1 want 0", i); end
            cycle();
        end
        rdy = '0;
    endtask

    task automatic test_random();
        DISPATCH_RS_PACKET exp;
        logic [31:0] r;
        drain();
        for (int c = 0; c < 400; c++) begin
            r = $urandom;
            set_group(r[MW-1:0]);
            rdy = r[MW+7:8];
            pipe_flush = (r[31:27] == 5'd0);
            #1;
            vectors++;
            if (q_count !== CW'(mq.size())) begin miscompares++; $display("FAIL rand_count[%0d] got %0d want %0d", c, q_count, mq.size()); end
            vectors++;
            if (in_ready !== ((DEPTH - mq.size()) >= MW)) begin miscompares++; $display("FAIL rand_ready[%0d] got %b", c, in_ready); end
            for (int k = 0; k < MW; k++) begin
                exp = (k < mq.size()) ? mq[k] : '0;
                vectors++;
                if (dispatch_pkt[k] !== exp) begin miscompares++; $display("FAIL rand_lane%0d[%0d] got %h want %h", k, c, dispatch_pkt[k], exp); end
            end
            cycle();
        end
        pipe_flush = 1'b0;
        rdy = '0;
    endtask

    task automatic test_mid_reset();
        drain();
        set_group(4'b1111); cycle();
        set_group(4'b0111); cycle();
        set_group('0);
        rdy = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (q_count !== 0) begin miscompares++; $display("FAIL mreset_count got %0d want 0", q_count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mreset_ready got %b want 1", in_ready); end
        for (int k = 0; k < MW; k++) begin
            vectors++;
            if (dispatch_pkt[k].packet_valid !== 1'b0) begin miscompares++; $display("FAIL mreset_lane%0d got 1 want 0", k); end
        end
        mq.delete();
        @(posedge clk);
        #1;
        vectors++; if (q_count !== 0) begin miscompares++; $display("FAIL mreset_hold got %0d want 0", q_count); end
        rst_n = 1'b1;
        rdy = '0;
        cycle();
        vectors++; if (q_empty !== 1'b1) begin miscompares++; $display("FAIL mreset_after got %b want 1", q_empty); end
    endtask

    initial begin
        set_group('0);
        test_reset();
        test_four_lanes();
        test_sparse_mask();
        test_partial_accept();
        test_backpressure();
        test_flush();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
